// File: rtl/iom_bus_pkg.sv
// Shared types and constants for the IOM bus-cycle master.
// Optional feature macro used by this slice: IOM_WAIT_TIMEOUT_EN.
package iom_bus_pkg;

  // One-hot bus-cycle state.
  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    T1   = 5'b00010,
    T2   = 5'b00100,
    T3   = 5'b01000,
    T4   = 5'b10000
  } bus_state_e;

  localparam logic       STROBE_OFF = 1'b1;   // inactive level of RD/WR
  localparam logic [1:0] CS_IDLE    = 2'b11;  // no bank selected

  // One-hot code for a requester index.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Active-low chip select for the bank addressed by the bank bit.
  function automatic logic [1:0] bank_cs_n(input logic bank);
    return bank ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/iom_rr_arb2.sv
// Combinational two-way round-robin pick: pointer requester first, then the other.
module iom_rr_arb2
  import iom_bus_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  input  logic       ptr_i,
  output logic       valid_o,
  output logic       winner_o
);

  logic [1:0] elig;

  // Drop masked requesters, then favour the pointer, falling back to the other one.
  always_comb begin
    elig     = req_i & ~mask_i;
    valid_o  = |elig;
    winner_o = elig[ptr_i] ? ptr_i : ~ptr_i;
  end

endmodule

// File: rtl/iom_bus_arbiter.sv
// Bus-cycle master and two-requester arbiter for the shared memory/IO bus.
// Runs T1/T2/T3(wait)/T4 cycles for requester 0 (CPU) and 1 (DMA), granting
// round-robin, with back-to-back cycles straight from T4 when the other side waits.
// Optional feature macro: IOM_WAIT_TIMEOUT_EN (bounded T3 wait with err pulse).
module iom_bus_arbiter
  import iom_bus_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 8,
  parameter int BANK_BIT = 19,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        rnw,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
`ifdef IOM_WAIT_TIMEOUT_EN
  output logic              err,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] Address,
  output logic              ALE,
  output logic              RD,
  output logic              WR,
  output logic [1:0]        CS_n,
  output logic [DATA_W-1:0] Dout,
  input  logic [DATA_W-1:0] Din,
  input  logic              READY
);

  bus_state_e        state_q;
  logic              ptr_q;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rnw_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        gnt_q;
  logic [1:0]        done_q;
  logic              ale_q;
  logic              rd_q;
  logic              wr_q;
  logic [1:0]        cs_n_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] rdata_q;

  logic [1:0]        arb_mask;
  logic              arb_valid;
  logic              arb_winner;
  logic              launch;
  logic              timeout_hit;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_rnw;
  logic [DATA_W-1:0] sel_wdata;

`ifdef IOM_WAIT_TIMEOUT_EN
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  logic [WAIT_W-1:0] wait_q;
  logic              err_q;
`endif

  // In T4 the finishing owner is masked so the other side can go back-to-back.
  always_comb begin
    arb_mask = (state_q == T4) ? onehot2(owner_q) : 2'b00;
  end

  iom_rr_arb2 u_arb (
    .req_i    (req),
    .mask_i   (arb_mask),
    .ptr_i    (ptr_q),
    .valid_o  (arb_valid),
    .winner_o (arb_winner)
  );

  // Decide whether a new cycle starts and pick the winner's request fields.
  // NOTE: every always_comb output gets a value on every path (defaults first), otherwise a latch is inferred.
  always_comb begin
    launch      = arb_valid && ((state_q == IDLE) || (state_q == T4));
    sel_addr    = arb_winner ? addr1  : addr0;
    sel_rnw     = arb_winner ? rnw[1] : rnw[0];
    sel_wdata   = arb_winner ? wdata1 : wdata0;
    timeout_hit = 1'b0;
`ifdef IOM_WAIT_TIMEOUT_EN
    timeout_hit = (state_q == T3) && !READY && (wait_q == WAIT_W'(MAX_WAIT - 1));
`endif
  end

`ifdef IOM_WAIT_TIMEOUT_EN
  // Count READY-low cycles spent in T3; cleared as T3 is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
    end else if (state_q == T2) begin
      wait_q <= '0;
    end else if ((state_q == T3) && !READY) begin
      wait_q <= wait_q + 1'b1;
    end
  end
`endif

  // Bus-cycle FSM with registered bus outputs and request latching.
  // NOTE: rst is synchronous here: it is sampled only inside the clocked block and acts on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      addr_q  <= '0;
      rnw_q   <= 1'b0;
      wdata_q <= '0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      ale_q   <= 1'b0;
      rd_q    <= STROBE_OFF;
      wr_q    <= STROBE_OFF;
      cs_n_q  <= CS_IDLE;
      dout_q  <= '0;
      rdata_q <= '0;
`ifdef IOM_WAIT_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments for all state, so every register sees pre-edge values.
      done_q <= 2'b00;
`ifdef IOM_WAIT_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: ;  // only leaves through launch below
        T1: begin
          state_q <= T2;
          ale_q   <= 1'b0;
          if (rnw_q) begin
            rd_q <= 1'b0;
          end else begin
            wr_q   <= 1'b0;
            dout_q <= wdata_q;
          end
        end
        T2: state_q <= T3;
        T3: begin
          if (READY || timeout_hit) begin
            state_q <= T4;
            rd_q    <= STROBE_OFF;
            wr_q    <= STROBE_OFF;
            cs_n_q  <= CS_IDLE;
            done_q  <= gnt_q;
            if (timeout_hit) begin
              rdata_q <= '1;
`ifdef IOM_WAIT_TIMEOUT_EN
              err_q   <= 1'b1;
`endif
            end else if (rnw_q) begin
              rdata_q <= Din;
            end
          end
        end
        T4: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
        end
        default: state_q <= IDLE;
      endcase

      // Start a new cycle from IDLE or straight out of T4.
      if (launch) begin
        state_q <= T1;
        owner_q <= arb_winner;
        ptr_q   <= ~arb_winner;
        addr_q  <= sel_addr;
        rnw_q   <= sel_rnw;
        wdata_q <= sel_wdata;
        gnt_q   <= onehot2(arb_winner);
        ale_q   <= 1'b1;
        cs_n_q  <= bank_cs_n(sel_addr[BANK_BIT]);
      end
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign Address = addr_q;
  assign ALE     = ale_q;
  assign RD      = rd_q;
  assign WR      = wr_q;
  assign CS_n    = cs_n_q;
  assign Dout    = dout_q;
`ifdef IOM_WAIT_TIMEOUT_EN
  assign err     = err_q;
`endif

endmodule

// File: tb/tb_iom_bus_arbiter.sv
// Bench for iom_bus_arbiter: directed steps plus randomized traffic, checked every
// cycle against a transaction-level model (queues per requester, cycle offsets).
module tb_iom_bus_arbiter;

  localparam int AW = 20;
  localparam int DW = 8;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req = 2'b00;
  logic [1:0]    rnw = 2'b00;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0, Din = '0;
  logic          READY = 1'b0;
  logic [1:0]    gnt, done, CS_n;
  logic [DW-1:0] rdata, Dout;
  logic [AW-1:0] Address;
  logic          ALE, RD, WR;
`ifdef IOM_WAIT_TIMEOUT_EN
  logic          err;
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  iom_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BANK_BIT(19), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .req(req), .rnw(rnw),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .done(done),
`ifdef IOM_WAIT_TIMEOUT_EN
    .err(err),
`endif
    .rdata(rdata), .Address(Address), .ALE(ALE), .RD(RD), .WR(WR),
    .CS_n(CS_n), .Dout(Dout), .Din(Din), .READY(READY)
  );

  always #5 clk = ~clk;

  // One bus transaction as seen by a requester; w = READY-low cycles before READY.
  typedef struct {
    bit            rnw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] din;
    int            w;
    bit            drop;
  } txn_t;

  int checks = 0;
  int failures = 0;

  txn_t q0[$];
  txn_t q1[$];

  // Reference model: the transaction on the bus and its cycle offset (0 = T1).
  bit            m_act = 1'b0;
  bit            m_own = 1'b0;
  txn_t          m_t;
  int            m_off = 0;
  int            m_t3 = 1;
  bit            m_to = 1'b0;
  bit            m_ptr = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] m_dout = '0;
  logic [AW-1:0] m_addr = '0;
  bit            rand_en = 1'b0;
  bit            rst_pulse = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input bit r, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input logic [DW-1:0] di, input int w, input bit drop);
    txn_t t;
    t.rnw = r; t.addr = a; t.wdata = wd; t.din = di; t.w = w; t.drop = drop;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.rnw   = 1'($urandom);
    t.addr  = AW'($urandom);
    t.wdata = DW'($urandom);
    t.din   = DW'($urandom);
    t.w     = int'($urandom_range(0, 3));
    t.drop  = ($urandom_range(0, 7) == 0);
`ifdef IOM_WAIT_TIMEOUT_EN
    if ($urandom_range(0, 7) == 0) t.w = 7;
`endif
    return t;
  endfunction

  // One clock cycle: drive inputs after the edge, check at negedge, then advance the model.
  task automatic cycle();
    txn_t       h0, h1, nt;
    bit   [1:0] rv, cand;
    bit         drv_rst, in_t3, can_arb, win;
    logic [1:0] e_gnt, e_done, e_cs;
    logic       e_ale, e_rd, e_wr, e_err, strobe;

    @(posedge clk); #1;
    if (rand_en) begin
      if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(rand_txn());
      if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(rand_txn());
    end
    drv_rst = rst_pulse;
    rst_pulse = 1'b0;
    rv = 2'b00;
    if (q0.size() > 0) begin
      h0 = q0[0];
      rv[0] = !(m_act && m_own == 1'b0 && h0.drop && m_off >= 1);
    end else h0 = rand_txn();
    if (q1.size() > 0) begin
      h1 = q1[0];
      rv[1] = !(m_act && m_own == 1'b1 && h1.drop && m_off >= 1);
    end else h1 = rand_txn();

    rst = drv_rst;
    req = rv;
    rnw = {h1.rnw, h0.rnw};
    addr0 = h0.addr; addr1 = h1.addr;
    wdata0 = h0.wdata; wdata1 = h1.wdata;
    in_t3 = m_act && m_off >= 2 && m_off <= 1 + m_t3;
    if (in_t3) begin
      READY = (m_off == 2 + m_t.w);
      Din = (m_off == 2 + m_t.w) ? m_t.din : DW'($urandom);
    end else begin
      READY = 1'($urandom);
      Din = DW'($urandom);
    end

    @(negedge clk);
    e_gnt = 2'b00; e_done = 2'b00; e_cs = 2'b11;
    e_ale = 1'b0; e_rd = 1'b1; e_wr = 1'b1; e_err = 1'b0;
    if (m_act) begin
      strobe = (m_off >= 1) && (m_off <= 1 + m_t3);
      e_gnt = 2'b01 << m_own;
      e_ale = (m_off == 0);
      if (m_off <= 1 + m_t3) e_cs = m_t.addr[19] ? 2'b01 : 2'b10;
      e_rd = !(strobe && m_t.rnw);
      e_wr = !(strobe && !m_t.rnw);
      if (m_off == 2 + m_t3) begin
        e_done = e_gnt;
        e_err = m_to;
      end
    end
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("done", 32'(done), 32'(e_done));
    check("ALE", 32'(ALE), 32'(e_ale));
    check("RD", 32'(RD), 32'(e_rd));
    check("WR", 32'(WR), 32'(e_wr));
    check("CS_n", 32'(CS_n), 32'(e_cs));
    check("Address", 32'(Address), 32'(m_addr));
    check("Dout", 32'(Dout), 32'(m_dout));
    check("rdata", 32'(rdata), 32'(m_rdata));
`ifdef IOM_WAIT_TIMEOUT_EN
    check("err", 32'(err), 32'(e_err));
`endif

    if (drv_rst) begin
      m_act = 1'b0; m_ptr = 1'b0; m_rdata = '0; m_dout = '0; m_addr = '0;
      q0.delete(); q1.delete();
    end else begin
      can_arb = 1'b0;
      cand = rv;
      if (m_act) begin
        if (m_off == 0 && !m_t.rnw) m_dout = m_t.wdata;
        if (m_off == 1 + m_t3) begin
          if (m_to) m_rdata = '1;
          else if (m_t.rnw) m_rdata = m_t.din;
        end
        if (m_off == 2 + m_t3) begin
          if (m_own) void'(q1.pop_front()); else void'(q0.pop_front());
          m_act = 1'b0;
          can_arb = 1'b1;
          cand[m_own] = 1'b0;
        end else m_off++;
      end else can_arb = 1'b1;
      if (can_arb && cand != 2'b00) begin
        win = cand[m_ptr] ? m_ptr : !m_ptr;
        nt = win ? h1 : h0;
        m_t = nt;
        m_act = 1'b1; m_own = win; m_off = 0; m_ptr = !win;
        m_to = TMO && (nt.w >= MW);
        m_t3 = m_to ? MW : nt.w + 1;
        m_addr = nt.addr;
      end
    end
  endtask

  task automatic run_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (!m_act && q0.size() == 0 && q1.size() == 0) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values are checked by the first cycles (rst high at the first edge).
    cycle();
    cycle();

    // CPU read, no wait states.
    q0.push_back(mk(1'b1, 20'h0_1234, 8'h00, 8'hA5, 0, 1'b0));
    run_idle(20);
    check("tp_read_rdata", 32'(rdata), 32'h0000_00A5);

    // DMA write into bank 1 with three wait states; rdata must hold.
    q1.push_back(mk(1'b0, 20'h8_0010, 8'h3C, 8'h00, 3, 1'b0));
    run_idle(20);
    check("tp_write_rdata_hold", 32'(rdata), 32'h0000_00A5);
    check("tp_write_dout", 32'(Dout), 32'h0000_003C);

    // Both requesting after reset: 0,1,0,1 back-to-back.
    rst_pulse = 1'b1;
    cycle();
    q0.push_back(mk(1'b1, 20'h0_0100, 8'h11, 8'h5A, 0, 1'b0));
    q0.push_back(mk(1'b0, 20'h0_0101, 8'h22, 8'h00, 1, 1'b0));
    q1.push_back(mk(1'b0, 20'h8_0200, 8'h33, 8'h00, 0, 1'b0));
    q1.push_back(mk(1'b1, 20'h8_0201, 8'h44, 8'hC3, 2, 1'b0));
    run_idle(40);
    check("tp_rr_last_rdata", 32'(rdata), 32'h0000_00C3);

    // Reset in the middle of a read's T3.
    q0.push_back(mk(1'b1, 20'h0_0F00, 8'h00, 8'h77, 3, 1'b0));
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (m_act && m_off == 2) break;
    end
    rst_pulse = 1'b1;
    cycle();
    cycle();
    check("tp_rst_gnt", 32'(gnt), 32'h0);
    check("tp_rst_cs", 32'(CS_n), 32'h3);

    // Requester 0 drops req in T2; the cycle still completes.
    q0.push_back(mk(1'b1, 20'h0_0ABC, 8'h00, 8'h9E, 1, 1'b1));
    run_idle(20);
    check("tp_drop_rdata", 32'(rdata), 32'h0000_009E);

`ifdef IOM_WAIT_TIMEOUT_EN
    // READY stuck low: forced T4 with err and all-ones rdata.
    q1.push_back(mk(1'b1, 20'h8_0ABC, 8'h00, 8'h12, 9, 1'b0));
    run_idle(30);
    check("tp_timeout_rdata", 32'(rdata), 32'h0000_00FF);
`endif

    // Randomized traffic.
    rand_en = 1'b1;
    for (int i = 0; i < 600; i++) cycle();
    rand_en = 1'b0;
    run_idle(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
